// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// SCL and SDA are open-drain: each line is either pulled to 0 or released.
module i2c_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       go,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_ADDR_ACK = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_DATA_ACK = 3'd5;
  localparam logic [2:0] S_STOP     = 3'd6;

  logic [2:0]       st_q, st_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             tick_c;
  logic             sda_in_c;
  logic [7:0]       addr_byte_c;
  logic             slot_scl_low_c;

  assign tick_c      = busy_q && (div_q == DIV_W'(CLK_DIV - 1));
  assign sda_in_c    = sda;
  assign addr_byte_c = {addr_d, rw_d};

  // Request acceptance, quarter-tick divider and protocol sequencing.
  always_comb begin
    st_d    = st_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nack_d  = nack_q;
    rdata_d = rdata_q;
    if (!busy_q) begin
      div_d = '0;
      if (go) begin
        st_d    = S_START;
        qtr_d   = 2'd0;
        bit_d   = 3'd7;
        addr_d  = addr;
        rw_d    = rw;
        wdata_d = wdata;
        busy_d  = 1'b1;
        nack_d  = 1'b0;
      end
    end else begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
      if (tick_c) begin
        qtr_d = qtr_q + 2'd1;
        // End of q2 is the SCL-high sampling point of every slot.
        if (qtr_q == 2'd2) begin
          if (st_q == S_ADDR_ACK && sda_in_c) nack_d = 1'b1;
          if (st_q == S_DATA_ACK && !rw_q && sda_in_c) nack_d = 1'b1;
          if (st_q == S_DATA && rw_q) rdata_d = {rdata_q[6:0], sda_in_c};
        end
        if (qtr_q == 2'd3) begin
          bit_d = bit_q - 3'd1;
          case (st_q)
            S_START: begin
              st_d  = S_ADDR;
              bit_d = 3'd7;
            end
            S_ADDR:     if (bit_q == 3'd0) st_d = S_ADDR_ACK;
            S_ADDR_ACK: begin
              st_d  = nack_q ? S_STOP : S_DATA;
              bit_d = 3'd7;
            end
            S_DATA:     if (bit_q == 3'd0) st_d = S_DATA_ACK;
            S_DATA_ACK: st_d = S_STOP;
            S_STOP: begin
              st_d   = S_IDLE;
              busy_d = 1'b0;
              done_d = 1'b1;
            end
            default:    st_d = S_IDLE;
          endcase
        end
      end
    end
  end

  assign slot_scl_low_c = (qtr_d == 2'd0) || (qtr_d == 2'd3);

  // Line drive levels for the upcoming quarter, registered with the state.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (st_d)
      S_START:    sda_oe_d = (qtr_d != 2'd0);
      S_ADDR: begin
        scl_oe_d = slot_scl_low_c;
        sda_oe_d = !addr_byte_c[bit_d];
      end
      S_ADDR_ACK: scl_oe_d = slot_scl_low_c;
      S_DATA: begin
        scl_oe_d = slot_scl_low_c;
        sda_oe_d = !rw_d && !wdata_d[bit_d];
      end
      S_DATA_ACK: scl_oe_d = slot_scl_low_c;
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d != 2'd3);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases both bus lines at once.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      st_q     <= S_IDLE;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd7;
      div_q    <= '0;
      addr_q   <= 7'd0;
      rw_q     <= 1'b0;
      wdata_q  <= 8'd0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      rdata_q  <= 8'd0;
    end else begin
      st_q     <= st_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign scl   = scl_oe_q ? 1'b0 : 1'bz;
  assign sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign busy  = busy_q;
  assign done  = done_q;
  assign nack  = nack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: pulled-up bus, edge-driven slave at 0x42, bus monitor,
// directed vector table, randomized transactions and two hand sequences.
module tb_i2c_master;

  localparam int unsigned CLK_DIV  = 4;
  localparam logic [6:0]  SLV_ADDR = 7'h42;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       ack_data;
    logic [7:0] tx;
    logic       exp_nack;
    int         exp_cyc;
    logic [7:0] exp_rdata;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    int         exp_pulses;
  } vec_t;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic       go     = 1'b0;
  logic [6:0] addr   = 7'd0;
  logic       rw     = 1'b0;
  logic [7:0] wdata  = 8'd0;
  logic       busy, done, nack;
  logic [7:0] rdata;
  wire        scl_w;
  wire        sda_w;

  logic        slv_drv      = 1'b0;
  logic        slv_ack_data = 1'b1;
  logic [7:0]  slv_tx       = 8'd0;
  logic [31:0] mon_bits     = '0;
  int          mon_n        = 0;
  logic        mon_stop     = 1'b0;
  logic        scl_p        = 1'b1;
  logic        sda_p        = 1'b1;

  int cyc      = 0;
  int done_cnt = 0;
  int n_chk    = 0;
  int n_err    = 0;

  pullup (scl_w);
  pullup (sda_w);
  assign sda_w = slv_drv ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .sysclk(sysclk), .rst(rst), .go(go), .addr(addr), .rw(rw), .wdata(wdata),
    .scl(scl_w), .sda(sda_w), .busy(busy), .done(done), .nack(nack), .rdata(rdata)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) if (done) done_cnt++;

  function automatic logic [7:0] mon_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = mon_bits[base+i];
    return b;
  endfunction

  // Bus monitor and slave: START/STOP detection, bit capture on SCL rise,
  // slave response decided on SCL fall for the slot that follows.
  always @(negedge sysclk) begin
    logic [7:0] b0;
    logic       hit;
    if (rst) begin
      slv_drv = 1'b0;
    end else if (scl_w && scl_p && sda_p && !sda_w) begin
      mon_n = 0; mon_stop = 1'b0; mon_bits = '0; slv_drv = 1'b0;
    end else if (scl_w && scl_p && !sda_p && sda_w) begin
      mon_stop = 1'b1; slv_drv = 1'b0;
    end else if (scl_w && !scl_p) begin
      if (mon_n < 32) mon_bits[mon_n] = sda_w;
      mon_n++;
    end else if (!scl_w && scl_p) begin
      b0  = mon_byte(0);
      hit = (b0[7:1] == SLV_ADDR);
      if (mon_n == 8)                     slv_drv = hit;
      else if (mon_n >= 9 && mon_n <= 16) slv_drv = hit && b0[0] && !slv_tx[16-mon_n];
      else if (mon_n == 17)               slv_drv = hit && !b0[0] && slv_ack_data;
      else                                slv_drv = 1'b0;
    end
    scl_p = scl_w;
    sda_p = sda_w;
  end

  // Transaction-level reference: outcome follows only from who answers.
  function automatic vec_t model(input logic [6:0] a, input logic r, input logic [7:0] wd,
                                 input logic ack, input logic [7:0] tx, input logic [7:0] prev);
    vec_t v;
    logic hit;
    hit          = (a == SLV_ADDR);
    v.addr       = a;
    v.rw         = r;
    v.wdata      = wd;
    v.ack_data   = ack;
    v.tx         = tx;
    v.exp_nack   = !hit || (!r && !ack);
    v.exp_cyc    = (hit ? 80 : 44) * CLK_DIV;
    v.exp_rdata  = (r && hit) ? tx : prev;
    v.exp_b0     = {a, r};
    v.exp_b1     = r ? tx : wd;
    v.exp_pulses = hit ? 19 : 10;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int inject, input logic rel_rst);
    int   acc, dur, d0;
    logic got;
    @(negedge sysclk);
    addr = v.addr; rw = v.rw; wdata = v.wdata;
    slv_ack_data = v.ack_data; slv_tx = v.tx;
    go = 1'b1;
    if (rel_rst) rst = 1'b0;
    d0 = done_cnt;
    @(posedge sysclk); #1;
    acc = cyc;
    chk("busy_on_accept", 32'(busy), 32'd1);
    chk("nack_clear_on_accept", 32'(nack), 32'd0);
    got = 1'b0; dur = 0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge sysclk);
      go = (inject != 0) && (cyc == acc + inject);
      if (go) addr = 7'h11;
      if (done) begin got = 1'b1; dur = cyc - acc; end
    end
    go = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("duration", 32'(dur), 32'(v.exp_cyc));
    chk("nack", 32'(nack), 32'(v.exp_nack));
    chk("rdata", 32'(rdata), 32'(v.exp_rdata));
    chk("busy_clear_with_done", 32'(busy), 32'd0);
    chk("addr_byte_on_bus", 32'(mon_byte(0)), 32'(v.exp_b0));
    chk("scl_pulses", 32'(mon_n), 32'(v.exp_pulses));
    chk("stop_seen", 32'(mon_stop), 32'd1);
    if (v.exp_pulses == 19) chk("data_byte_on_bus", 32'(mon_byte(9)), 32'(v.exp_b1));
    if (v.exp_pulses == 19 && v.rw) chk("master_nack_slot", 32'(mon_bits[17]), 32'd1);
    @(negedge sysclk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [7:0] exp_rd;
    logic [6:0] ra;
    int   acc, d0;

    //           addr   rw    wdata  ack   tx     nack  cyc  rdata  b0     b1     pulses
    tbl[0] = '{7'h42, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 320, 8'h00, 8'h84, 8'hA5, 19};
    tbl[1] = '{7'h42, 1'b1, 8'h00, 1'b1, 8'h3C, 1'b0, 320, 8'h3C, 8'h85, 8'h3C, 19};
    tbl[2] = '{7'h11, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b1, 176, 8'h3C, 8'h22, 8'h00, 10};
    tbl[3] = '{7'h42, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 320, 8'h3C, 8'h84, 8'hFF, 19};
    tbl[4] = '{7'h11, 1'b1, 8'h00, 1'b1, 8'h77, 1'b1, 176, 8'h3C, 8'h23, 8'h00, 10};
    tbl[5] = '{7'h42, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0, 320, 8'h3C, 8'h84, 8'h5A, 19};

    repeat (3) @(negedge sysclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_nack", 32'(nack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_scl_released", 32'(scl_w), 32'd1);
    chk("rst_sda_released", 32'(sda_w), 32'd1);

    // Directed vectors; the last one also pulses go with another address at tick 20.
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      run_txn(tbl[i], (i == 5) ? 20 * CLK_DIV : 0, (i == 0));
      if (i == 5) begin
        repeat (100) @(negedge sysclk);
        chk("go_while_busy_no_restart", 32'(busy), 32'd0);
        chk("go_while_busy_single_done", 32'(done_cnt - d0), 32'd1);
      end
    end
    exp_rd = 8'h3C;

    for (int i = 0; i < 12; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV_ADDR;
      v  = model(ra, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), exp_rd);
      run_txn(v, 0, 1'b0);
      exp_rd = v.exp_rdata;
    end

    // Reset in the middle of the address byte, then a fresh read.
    @(negedge sysclk);
    addr = SLV_ADDR; rw = 1'b1; slv_tx = 8'hC3; go = 1'b1;
    @(posedge sysclk); #1;
    acc = cyc;
    @(negedge sysclk);
    go = 1'b0;
    for (int k = 0; k < 1000 && cyc < acc + 30 * CLK_DIV; k++) @(negedge sysclk);
    chk("busy_before_mid_reset", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_scl_released", 32'(scl_w), 32'd1);
    chk("mid_rst_sda_released", 32'(sda_w), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_nack", 32'(nack), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    @(negedge sysclk);
    v = model(SLV_ADDR, 1'b1, 8'h00, 1'b1, 8'h96, 8'h00);
    run_txn(v, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 125, giving sysclk cycles per quarter SCL period (50 MHz -> 100 kHz).
REQ-002 The block SHALL have port sysclk, input, 1 bit: the single system clock; all logic is sequential on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port go, input, 1 bit: transaction request, sampled on sysclk.
REQ-005 The block SHALL have port addr, input, 7 bits: target slave address.
REQ-006 The block SHALL have port rw, input, 1 bit: 0 = write, 1 = read.
REQ-007 The block SHALL have port wdata, input, 8 bits: the byte to write.
REQ-008 The block SHALL have port scl, output, 1 bit: open-drain emulation, either driven 0 or high-Z.
REQ-009 The block SHALL have port sda, inout, 1 bit: open-drain, either driven 0 or high-Z, and read back for sampling.
REQ-010 The block SHALL have port busy, output, 1 bit: transaction in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port nack, output, 1 bit: the last transaction saw a NACK.
REQ-013 The block SHALL have port rdata, output, 8 bits: the byte read.

Function
REQ-014 A quarter-tick SHALL fire once every CLK_DIV sysclk cycles while busy, and its counter SHALL restart at 0 on request acceptance.
REQ-015 A request SHALL be accepted on a sysclk edge with go=1 and busy=0; on that edge addr, rw and wdata SHALL be latched and busy set to 1.
REQ-016 go SHALL be ignored while busy=1.
REQ-017 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP; every non-IDLE state SHALL advance only on quarter-ticks.
REQ-018 START SHALL take 4 ticks, with SCL released throughout and SDA released for tick 0, low for ticks 1-3; SCL SHALL then go low on entry to ADDR.
REQ-019 Each bit slot SHALL take 4 ticks:
- q0: SCL low, SDA set to the bit.
- q1: SCL released.
- q2: SCL high, SDA sampled.
- q3: SCL low.
REQ-020 ADDR SHALL send addr[6] first through addr[0], then rw, for 8 slots total.
REQ-021 In ADDR_ACK the master SHALL release SDA; a sample of 0 is ACK, and a sample of 1 SHALL set nack and go to STOP, skipping DATA.
REQ-022 In DATA with rw=0, the block SHALL send wdata MSB first; in DATA_ACK it SHALL release SDA and set nack if the sample is 1.
REQ-023 In DATA with rw=1, the block SHALL release SDA and shift samples MSB first into rdata; in DATA_ACK it SHALL release SDA (master NACK, end of read).
REQ-024 STOP SHALL take 4 ticks: SDA low with SCL low on tick 0, SCL released on tick 1, SDA released on tick 3, then return to IDLE.
REQ-025 Total duration SHALL be 80 ticks, or 44 ticks on address NACK; done SHALL pulse for 1 cycle on the IDLE-entry edge, and busy SHALL clear on that same edge.
REQ-026 nack SHALL clear on acceptance and hold its value from completion until the next acceptance.
REQ-027 rdata SHALL be updated only in read transactions and SHALL hold its value otherwise.
REQ-028 Clock stretching, arbitration and multi-byte transfers SHALL NOT be supported; the block SHALL NOT sample SCL.

Reset
REQ-029 The rst=1 input SHALL immediately force IDLE, release scl and sda (high-Z), and clear busy, done, nack, rdata and the tick counter, including mid-transaction.
REQ-030 After rst is deasserted, the block SHALL accept go on the first qualifying edge.

Verification (CLK_DIV=4, slave model with pull-ups)
REQ-031 Write: addr=0x42, rw=0, wdata=0xA5, slave ACKs -> SDA bytes 0x84 and 0xA5 are seen on SCL rising edges; done occurs 320 cycles after accept with nack=0.
REQ-032 Read: addr=0x42, rw=1, slave returns 0x3C -> rdata=0x3C, master leaves SDA high in the ACK slot, nack=0, done occurs at 320 cycles.
REQ-033 Address NACK: no slave at 0x11 -> STOP follows the 9th SCL pulse, done occurs at 176 cycles with nack=1, and no data slots appear.
REQ-034 Data NACK: write 0x42/0xFF and the slave NACKs the data byte -> nack=1, a full 80 ticks elapse, and STOP is present.
REQ-035 go while busy: pulse go at tick 20 with a different addr -> the first transaction is unchanged, and only one done pulse occurs.
REQ-036 Reset mid-byte: assert rst at tick 30 -> scl and sda are high-Z and busy=0 before the next sysclk edge; a new request then completes normally.
